// File: rtl/mux4_sel_arb_if.sv
// rtl/mux4_sel_arb_if.sv - request/beat/select bundle between sources, arbiter and 4:1 select mux
interface mux4_sel_arb_if;
  logic [3:0] req;
  logic       last;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] grant;
  logic       sel0_l;
  logic       sel1_l;
  logic       sel2_l;
  logic       sel3_l;

  modport master (
    output req, last, out_ready,
    input  out_valid, grant, sel0_l, sel1_l, sel2_l, sel3_l
  );

  modport slave (
    input  req, last, out_ready,
    output out_valid, grant, sel0_l, sel1_l, sel2_l, sel3_l
  );
endinterface

// File: rtl/mux4_sel_arb.sv
// rtl/mux4_sel_arb.sv - 4-source beat arbiter with registered one-cold mux selects
// Round-robin or fixed priority, beat-limited grants, back-to-back re-arbitration on release.
module mux4_sel_arb #(
  parameter int MAX_BEATS = 16,
  parameter bit RR        = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mux4_sel_arb_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] sel_l_q, sel_l_d;
  logic       out_valid_q, out_valid_d;

  logic [3:0] win;
  logic [1:0] g_idx;
  logic [1:0] ptr_rel;
  logic [1:0] base;
  logic       g_req;
  logic       accept;
  logic       limit_hit;
  logic       abort;
  logic       rel;

  // Highest priority is start, then start+1, ... wrapping; lowest offset is written last and wins.
  function automatic logic [3:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [3:0] w;
    logic [1:0] idx;
    w = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) w = 4'b0001 << idx;
    end
    return w;
  endfunction

  always_comb begin
    g_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant_q[i]) g_idx = 2'(i);
    end
  end

  assign g_req     = |(bus.req & grant_q);
  assign accept    = (state_q == BUSY) && out_valid_q && bus.out_ready;
  assign limit_hit = accept && ((bcnt_q + 8'd1) == 8'(MAX_BEATS));
  assign abort     = (state_q == BUSY) && !g_req;
  assign rel       = abort || (accept && bus.last) || limit_hit;
  assign ptr_rel   = RR ? (g_idx + 2'd1) : 2'd0;
  assign base      = RR ? ptr_q : 2'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      bcnt_q      <= 8'd0;
      grant_q     <= 4'b0000;
      sel_l_q     <= 4'b1110;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      bcnt_q      <= bcnt_d;
      grant_q     <= grant_d;
      sel_l_q     <= sel_l_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Fixed priority regrants the releasing source when it still requests; only round-robin masks it.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    win     = 4'b0000;
    case (state_q)
      IDLE: begin
        win = pick(bus.req, base);
        if (|win) begin
          state_d = BUSY;
          bcnt_d  = 8'd0;
        end
      end
      BUSY: begin
        if (rel) begin
          ptr_d   = ptr_rel;
          bcnt_d  = 8'd0;
          win     = pick(bus.req & (RR ? ~grant_q : 4'b1111), ptr_rel);
          state_d = (|win) ? BUSY : IDLE;
        end else if (accept && (bcnt_q != 8'(MAX_BEATS))) begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A grant following an abort starts with out_valid low; selects park on the last winner in IDLE.
  always_comb begin
    grant_d     = grant_q;
    sel_l_d     = sel_l_q;
    out_valid_d = out_valid_q;
    if (|win) begin
      grant_d     = win;
      sel_l_d     = ~win;
      out_valid_d = !abort;
    end else if (state_d == BUSY) begin
      out_valid_d = g_req;
    end else begin
      grant_d     = 4'b0000;
      out_valid_d = 1'b0;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel0_l    = sel_l_q[0];
  assign bus.sel1_l    = sel_l_q[1];
  assign bus.sel2_l    = sel_l_q[2];
  assign bus.sel3_l    = sel_l_q[3];

endmodule

// File: tb/tb_mux4_sel_arb.sv
// tb/tb_mux4_sel_arb.sv - scoreboard bench for three arbiter configurations on shared stimulus
module tb_mux4_sel_arb;

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] sel_l;
    logic       valid;
  } exp_t;

  typedef exp_t [2:0] exp3_t;

  typedef struct {
    int   dut;
    int   tag;
    exp_t val;
  } dir_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       last;
  logic       out_ready;

  int checks   = 0;
  int failures = 0;

  exp3_t sbq[$];
  dir_t  dq[$];

  int mg[3];
  int mptr[3];
  int mcnt[3];
  int mov[3];
  int mpark[3];
  int rrp[3] = '{1, 0, 1};
  int mbp[3] = '{16, 16, 4};

  always #5 clk = ~clk;

  mux4_sel_arb_if ifa ();
  mux4_sel_arb_if ifb ();
  mux4_sel_arb_if ifc ();

  assign ifa.req = req;  assign ifa.last = last;  assign ifa.out_ready = out_ready;
  assign ifb.req = req;  assign ifb.last = last;  assign ifb.out_ready = out_ready;
  assign ifc.req = req;  assign ifc.last = last;  assign ifc.out_ready = out_ready;

  mux4_sel_arb #(.MAX_BEATS(16), .RR(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  mux4_sel_arb #(.MAX_BEATS(16), .RR(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  mux4_sel_arb #(.MAX_BEATS(4),  .RR(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

  exp_t obs[3];
  assign obs[0] = {ifa.grant, ifa.sel3_l, ifa.sel2_l, ifa.sel1_l, ifa.sel0_l, ifa.out_valid};
  assign obs[1] = {ifb.grant, ifb.sel3_l, ifb.sel2_l, ifb.sel1_l, ifb.sel0_l, ifb.out_valid};
  assign obs[2] = {ifc.grant, ifc.sel3_l, ifc.sel2_l, ifc.sel1_l, ifc.sel0_l, ifc.out_valid};

  // Reference model: sources as integers, first requester found walking from the pointer.
  function automatic int arb(input logic [3:0] r, input int start, input int mask);
    int idx;
    for (int i = 0; i < 4; i++) begin
      idx = (start + i) % 4;
      if (r[idx] && idx != mask) return idx;
    end
    return -1;
  endfunction

  function automatic exp_t mk_exp(input int g, input int park, input int v);
    exp_t x;
    logic [3:0] one;
    one     = 4'b0001;
    x.grant = (g < 0) ? 4'b0000 : (one << g);
    x.sel_l = ~(one << park);
    x.valid = (v != 0);
    return x;
  endfunction

  function automatic exp_t busy_e(input logic [3:0] g, input logic v);
    exp_t x;
    x.grant = g;
    x.sel_l = ~g;
    x.valid = v;
    return x;
  endfunction

  function automatic exp_t idle_e(input logic [3:0] sel_l);
    exp_t x;
    x.grant = 4'b0000;
    x.sel_l = sel_l;
    x.valid = 1'b0;
    return x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mg[k] = -1; mptr[k] = 0; mcnt[k] = 0; mov[k] = 0; mpark[k] = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic l, input logic rd);
    exp3_t e;
    int    w;
    bit    acc, abrt, rel;
    for (int k = 0; k < 3; k++) begin
      if (mg[k] < 0) begin
        w = arb(r, (rrp[k] != 0) ? mptr[k] : 0, -1);
        if (w >= 0) begin
          mg[k] = w; mcnt[k] = 0; mov[k] = 1; mpark[k] = w;
        end
      end else begin
        acc  = (mov[k] == 1) && rd;
        abrt = !r[mg[k]];
        rel  = abrt || (acc && l) || (acc && (mcnt[k] + 1 == mbp[k]));
        if (rel) begin
          if (rrp[k] != 0) mptr[k] = (mg[k] + 1) % 4;
          w = arb(r, (rrp[k] != 0) ? mptr[k] : 0, (rrp[k] != 0) ? mg[k] : -1);
          if (w >= 0) begin
            mg[k] = w; mcnt[k] = 0; mov[k] = abrt ? 0 : 1; mpark[k] = w;
          end else begin
            mg[k] = -1; mov[k] = 0;
          end
        end else begin
          if (acc) mcnt[k] = mcnt[k] + 1;
          mov[k] = 1;
        end
      end
      e[k] = mk_exp(mg[k], mpark[k], mov[k]);
    end
    sbq.push_back(e);
  endtask

  task automatic exp_dut(input int k, input int tag, input exp_t v);
    dir_t d;
    d.dut = k; d.tag = tag; d.val = v;
    dq.push_back(d);
  endtask

  task automatic exp_all(input int tag, input exp_t v);
    for (int k = 0; k < 3; k++) exp_dut(k, tag, v);
  endtask

  task automatic step(input logic [3:0] r, input logic l, input logic rd);
    req = r; last = l; out_ready = rd;
    model_step(r, l, rd);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0000; last = 1'b0; out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: pops one scoreboard entry per cycle, plus any directed expectations and reset checks.
  initial begin
    exp3_t e;
    dir_t  d;
    exp_t  rst_v;
    rst_v = idle_e(4'b1110);
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (obs[k] !== e[k]) begin
            failures++;
            $display("FAIL sb dut%0d t=%0t: got grant=%b sel_l=%b valid=%b, expected grant=%b sel_l=%b valid=%b",
                     k, $time, obs[k].grant, obs[k].sel_l, obs[k].valid, e[k].grant, e[k].sel_l, e[k].valid);
          end
        end
      end
      while (dq.size() > 0) begin
        d = dq.pop_front();
        checks++;
        if (obs[d.dut] !== d.val) begin
          failures++;
          $display("FAIL req%0d dut%0d t=%0t: got grant=%b sel_l=%b valid=%b, expected grant=%b sel_l=%b valid=%b",
                   d.tag, d.dut, $time, obs[d.dut].grant, obs[d.dut].sel_l, obs[d.dut].valid,
                   d.val.grant, d.val.sel_l, d.val.valid);
        end
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ($countones(~obs[k].sel_l) != 1) begin
          failures++;
          $display("FAIL onecold dut%0d t=%0t: got sel_l=%b, expected exactly one zero", k, $time, obs[k].sel_l);
        end
      end
      #3;
      if (reset) begin
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (obs[k] !== rst_v) begin
            failures++;
            $display("FAIL reset dut%0d t=%0t: got grant=%b sel_l=%b valid=%b, expected grant=0000 sel_l=1110 valid=0",
                     k, $time, obs[k].grant, obs[k].sel_l, obs[k].valid);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] r_cur;
    logic [3:0] seq_a [5];
    reset = 1'b1; req = 4'b0000; last = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    #4;
    reset = 1'b0;

    // Single request grant, hold, then abort to idle with parked selects.
    exp_all(29, busy_e(4'b0100, 1'b1));
    step(4'b0100, 1'b0, 1'b0);
    exp_all(29, busy_e(4'b0100, 1'b1));
    step(4'b0100, 1'b0, 1'b0);
    exp_all(22, idle_e(4'b1011));
    step(4'b0000, 1'b0, 1'b1);

    // All requesting, single-beat transfers.
    do_reset();
    seq_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      exp_dut(0, 30, busy_e(seq_a[i], 1'b1));
      exp_dut(1, 30, busy_e(4'b0001, 1'b1));
      exp_dut(2, 30, busy_e(seq_a[i], 1'b1));
      step(4'b1111, 1'b1, 1'b1);
    end

    // Fixed priority starves source 3; round-robin alternates.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_dut(1, 31, busy_e(4'b0010, 1'b1));
      exp_dut(0, 31, busy_e((i % 2 == 0) ? 4'b0010 : 4'b1000, 1'b1));
      step(4'b1010, 1'b1, 1'b1);
    end

    // Beat limit of 4 without last.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_dut(2, 32, busy_e((i < 4) ? 4'b0001 : 4'b0010, 1'b1));
      exp_dut(0, 32, busy_e(4'b0001, 1'b1));
      step(4'b0011, 1'b0, 1'b1);
    end

    // last coinciding with the beat limit releases once.
    do_reset();
    for (int i = 0; i < 4; i++) step(4'b0011, 1'b0, 1'b1);
    exp_dut(2, 25, busy_e(4'b0010, 1'b1));
    exp_dut(0, 25, busy_e(4'b0010, 1'b1));
    step(4'b0011, 1'b1, 1'b1);
    exp_dut(2, 25, busy_e(4'b0001, 1'b1));
    step(4'b0011, 1'b1, 1'b1);

    // Abort of source 1 with nothing else pending.
    do_reset();
    exp_all(33, busy_e(4'b0010, 1'b1));
    step(4'b0010, 1'b0, 1'b1);
    exp_all(33, idle_e(4'b1101));
    step(4'b0000, 1'b0, 1'b1);
    exp_all(33, idle_e(4'b1101));
    step(4'b0000, 1'b0, 1'b1);

    // Asynchronous reset while source 3 is granted.
    exp_all(34, busy_e(4'b1000, 1'b1));
    step(4'b1000, 1'b0, 1'b0);
    do_reset();

    // Randomized traffic with occasional resets.
    r_cur = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 2) == 0) r_cur[$urandom_range(0, 3)] = ~r_cur[$urandom_range(0, 3)];
        if ($urandom_range(0, 9) == 0) r_cur = 4'($urandom_range(0, 15));
        step(r_cur, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
      end
    end

    @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
